// File: rtl/data_wb_if.sv
// Data-port Wishbone master for the openmips core: turns each single-cycle ram_* access into one classic
// Wishbone cycle and stalls the pipeline until it completes. Optional bus timeout: define WB_TIMEOUT_EN.
module data_wb_if #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    input  logic        cpu_ce_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq_o,
    output logic        bus_err_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic [1:0]  fsm_state
);

    // Handshake: a cycle is requested by holding cyc/stb with stable adr/dat/sel/we; the slave
    // completes it by raising wb_ack_i for one cycle. ack outside BUSY is ignored.
    typedef enum logic [1:0] {
        IDLE           = 2'd0,
        BUSY           = 2'd1,
        WAIT_FOR_STALL = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] rd_buf;
    logic        start;
    logic        timeout;

    if (2 ** TO_W <= TIMEOUT_CYCLES) begin : g_bad_cfg
        $error("data_wb_if: TO_W is too narrow for TIMEOUT_CYCLES");
    end

    assign start     = (state == IDLE) && cpu_ce_i && !flush_i;
    assign fsm_state = state;

`ifdef WB_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;

    // Abort fires in the BUSY cycle that follows TIMEOUT_CYCLES consecutive un-acked BUSY cycles.
    assign timeout = (state == BUSY) && !flush_i && !wb_ack_i
                     && (to_cnt == TO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if ((state == BUSY) && !flush_i && !wb_ack_i && !timeout) begin
            to_cnt <= to_cnt + TO_W'(1);
        end else begin
            to_cnt <= '0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = BUSY;
            end
            BUSY: begin
                if (flush_i)       state_nxt = IDLE;
                else if (wb_ack_i) state_nxt = (stall_i != 6'b0) ? WAIT_FOR_STALL : IDLE;
                else if (timeout)  state_nxt = IDLE;
            end
            WAIT_FOR_STALL: begin
                if (flush_i || (stall_i == 6'b0)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Combinational outputs are forced low while reset is held so ctrl never sees a stale request.
    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = 32'h0;
        bus_err_o  = 1'b0;
        if (rst) begin
            unique case (state)
                IDLE: begin
                    stallreq_o = cpu_ce_i && !flush_i;
                end
                BUSY: begin
                    stallreq_o = !flush_i && !wb_ack_i && !timeout;
                    bus_err_o  = timeout;
                    if (wb_ack_i && !flush_i && !wb_we_o) cpu_data_o = wb_dat_i;
                end
                WAIT_FOR_STALL: begin
                    cpu_data_o = rd_buf;
                end
                default: begin
                    stallreq_o = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_adr_o <= 32'h0;
            wb_dat_o <= 32'h0;
            wb_sel_o <= 4'h0;
            wb_we_o  <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        wb_adr_o <= cpu_addr_i;
                        wb_dat_o <= cpu_data_i;
                        wb_sel_o <= cpu_sel_i;
                        wb_we_o  <= cpu_we_i;
                        wb_stb_o <= 1'b1;
                        wb_cyc_o <= 1'b1;
                    end
                end
                BUSY: begin
                    if (flush_i || wb_ack_i || timeout) begin
                        wb_adr_o <= 32'h0;
                        wb_dat_o <= 32'h0;
                        wb_sel_o <= 4'h0;
                        wb_we_o  <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_cyc_o <= 1'b0;
                    end
                end
                default: begin
                    wb_stb_o <= 1'b0;
                    wb_cyc_o <= 1'b0;
                end
            endcase
        end
    end

    // Writes leave zero in the buffer so a stalled write also returns 0 to the memory stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_buf <= 32'h0;
        end else if (state == BUSY) begin
            if (flush_i)       rd_buf <= 32'h0;
            else if (wb_ack_i) rd_buf <= wb_we_o ? 32'h0 : wb_dat_i;
        end
    end

endmodule

// File: tb/tb_data_wb_if.sv
// Directed bench for data_wb_if: an access-level reference model checked every cycle, plus literal
// expectations for the documented scenarios (read, waited write, stalled read, flush, reset, timeout).
module tb_data_wb_if;

`ifdef WB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall_i = '0;
    logic        flush_i = 1'b0;
    logic        cpu_ce_i = 1'b0;
    logic        cpu_we_i = 1'b0;
    logic [31:0] cpu_addr_i = '0;
    logic [3:0]  cpu_sel_i = '0;
    logic [31:0] cpu_data_i = '0;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic        bus_err_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic [1:0]  fsm_state;

    data_wb_if #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
        .stallreq_o(stallreq_o), .bus_err_o(bus_err_o), .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int stb_cnt = 0;
    int stall_cnt = 0;
    int err_cnt = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding access, optionally a completed read parked while stalled.
    logic        m_busy, m_hold, m_we;
    logic [31:0] m_adr, m_dat, m_rd;
    logic [3:0]  m_sel;
    int          m_waits;

    function automatic logic timeout_now();
        return TO_EN && m_busy && !wb_ack_i && !flush_i && (m_waits == TO);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 1'b0; m_hold <= 1'b0; m_we <= 1'b0;
            m_adr <= '0; m_dat <= '0; m_rd <= '0; m_sel <= '0; m_waits <= 0;
        end else if (m_busy) begin
            if (flush_i) begin
                m_busy <= 1'b0; m_rd <= '0;
            end else if (wb_ack_i) begin
                m_busy <= 1'b0;
                m_rd   <= m_we ? 32'h0 : wb_dat_i;
                m_hold <= (stall_i != 6'b0);
            end else if (timeout_now()) begin
                m_busy <= 1'b0;
            end else begin
                m_waits <= m_waits + 1;
            end
        end else if (m_hold) begin
            if (flush_i || stall_i == 6'b0) m_hold <= 1'b0;
        end else if (cpu_ce_i && !flush_i) begin
            m_busy <= 1'b1; m_waits <= 0;
            m_adr <= cpu_addr_i; m_dat <= cpu_data_i; m_sel <= cpu_sel_i; m_we <= cpu_we_i;
        end
    end

    // scoreboard: every output compared against the model on each falling edge
    always @(negedge clk) begin
        logic        e_stall, e_err;
        logic [31:0] e_data;
        e_stall = 1'b0; e_err = 1'b0; e_data = 32'h0;
        if (rst) begin
            if (m_busy) begin
                e_stall = !flush_i && !wb_ack_i && !timeout_now();
                e_err   = timeout_now();
                if (wb_ack_i && !flush_i && !m_we) e_data = wb_dat_i;
            end else if (m_hold) begin
                e_data = m_rd;
            end else begin
                e_stall = cpu_ce_i && !flush_i;
            end
        end
        chk("wb_cyc", {31'b0, wb_cyc_o}, {31'b0, m_busy});
        chk("wb_stb", {31'b0, wb_stb_o}, {31'b0, m_busy});
        chk("wb_adr", wb_adr_o, m_busy ? m_adr : 32'h0);
        chk("wb_dat", wb_dat_o, m_busy ? m_dat : 32'h0);
        chk("wb_sel", {28'b0, wb_sel_o}, m_busy ? {28'b0, m_sel} : 32'h0);
        chk("wb_we", {31'b0, wb_we_o}, {31'b0, m_busy && m_we});
        chk("stallreq", {31'b0, stallreq_o}, {31'b0, e_stall});
        chk("cpu_data", cpu_data_o, e_data);
        chk("bus_err", {31'b0, bus_err_o}, {31'b0, e_err});
        if (rst && m_busy && wb_ack_i && !flush_i && !m_we) begin
            if (exp_q.size() == 0) chk("read_unexpected", 32'h1, 32'h0);
            else chk("read_result", cpu_data_o, exp_q.pop_front());
        end
        stb_cnt   += int'(wb_stb_o);
        stall_cnt += int'(stallreq_o);
        err_cnt   += int'(bus_err_o);
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_counts();
        stb_cnt = 0; stall_cnt = 0; err_cnt = 0;
    endtask

    task automatic request(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat);
        cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = adr; cpu_sel_i = sel; cpu_data_i = dat;
    endtask

    task automatic drop_request();
        cpu_ce_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = 32'hFFFF_FFFF; cpu_sel_i = 4'hC;
        cpu_data_i = 32'hA5A5_A5A5;
    endtask

    logic [31:0] tab_adr  [4] = '{32'h0000_1000, 32'h0000_1004, 32'h0000_2008, 32'h0000_300C};
    logic [31:0] tab_dat  [4] = '{32'h0102_0304, 32'hFFFF_0000, 32'h8000_0001, 32'h7E57_DA7A};
    logic [3:0]  tab_sel  [4] = '{4'hF, 4'h3, 4'hC, 4'h1};
    logic        tab_we   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int          tab_wait [4] = '{0, 2, 3, 1};

    initial begin
        // reset with a live request on the core side
        cpu_ce_i = 1'b1;
        repeat (2) step();
        chk("rst_stallreq", {31'b0, stallreq_o}, 32'h0);
        chk("rst_cyc", {31'b0, wb_cyc_o}, 32'h0);
        chk("rst_state", {30'b0, fsm_state}, 32'h0);
        cpu_ce_i = 1'b0;
        #2 rst = 1'b1;

        // zero-wait read
        step(); clr_counts();
        request(1'b0, 32'h0000_0100, 4'hF, 32'h0);
        exp_q.push_back(32'hDEAD_BEEF);
        step(); drop_request();
        wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
        #3 chk("rd0_data", cpu_data_o, 32'hDEAD_BEEF);
        step(); wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        step();
        chk("rd0_stb_cycles", stb_cnt, 1);
        chk("rd0_stall_cycles", stall_cnt, 1);

        // write with three wait states
        clr_counts();
        request(1'b1, 32'h0000_0200, 4'b0011, 32'h1234_5678);
        step(); drop_request();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) wb_ack_i = 1'b1;
            #3;
            chk("wr_adr_stable", wb_adr_o, 32'h0000_0200);
            chk("wr_dat_stable", wb_dat_o, 32'h1234_5678);
            chk("wr_sel_stable", {28'b0, wb_sel_o}, 32'h3);
            step();
        end
        wb_ack_i = 1'b0;
        #3 chk("wr_cpu_data", cpu_data_o, 32'h0);
        step();
        chk("wr_stb_cycles", stb_cnt, 4);
        chk("wr_stall_cycles", stall_cnt, 4);

        // ack under pipeline stall, core keeps its request asserted
        clr_counts();
        request(1'b0, 32'h0000_0300, 4'hF, 32'h0);
        exp_q.push_back(32'hCAFE_F00D);
        step();
        wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE_F00D; stall_i = 6'b000011;
        step(); wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        #3 chk("wfs1_data", cpu_data_o, 32'hCAFE_F00D);
        chk("wfs1_stallreq", {31'b0, stallreq_o}, 32'h0);
        chk("wfs1_state", {30'b0, fsm_state}, 32'h2);
        step(); stall_i = 6'b0;
        #3 chk("wfs2_data", cpu_data_o, 32'hCAFE_F00D);
        step(); drop_request();
        step();
        chk("wfs_stb_cycles", stb_cnt, 1);
        chk("wfs_idle", {30'b0, fsm_state}, 32'h0);

        // flush together with ack in the second BUSY cycle
        request(1'b0, 32'h0000_0400, 4'hF, 32'h0);
        step(); drop_request();
        step(); flush_i = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 32'h55AA_55AA;
        #3 chk("fl_data", cpu_data_o, 32'h0);
        chk("fl_stallreq", {31'b0, stallreq_o}, 32'h0);
        step(); flush_i = 1'b0; wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        #3 chk("fl_cyc", {31'b0, wb_cyc_o}, 32'h0);
        chk("fl_stb", {31'b0, wb_stb_o}, 32'h0);
        chk("fl_state", {30'b0, fsm_state}, 32'h0);

        // flush and stray ack while idle
        step(); request(1'b0, 32'h0000_0440, 4'hF, 32'h0); flush_i = 1'b1; wb_ack_i = 1'b1;
        wb_dat_i = 32'h1111_2222;
        #3 chk("idle_flush_stallreq", {31'b0, stallreq_o}, 32'h0);
        step(); drop_request(); flush_i = 1'b0; wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        #3 chk("idle_flush_stb", {31'b0, wb_stb_o}, 32'h0);

        // reset asserted mid-cycle while BUSY
        step(); request(1'b1, 32'h0000_0500, 4'hF, 32'h0000_AAAA);
        step(); drop_request();
        #2 rst = 1'b0;
        #1 chk("arst_cyc", {31'b0, wb_cyc_o}, 32'h0);
        chk("arst_stb", {31'b0, wb_stb_o}, 32'h0);
        chk("arst_adr", wb_adr_o, 32'h0);
        chk("arst_dat", wb_dat_o, 32'h0);
        step(); step();
        #2 rst = 1'b1;
        step();
        chk("arst_state", {30'b0, fsm_state}, 32'h0);

        // mixed reads/writes, each issued straight from the idle cycle after the previous ack
        for (int k = 0; k < 4; k++) begin
            request(tab_we[k], tab_adr[k], tab_sel[k], ~tab_dat[k]);
            if (!tab_we[k]) exp_q.push_back(tab_dat[k]);
            step();
            repeat (tab_wait[k]) step();
            wb_ack_i = 1'b1; wb_dat_i = tab_dat[k];
            step(); wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        end
        drop_request();
        step();

        // unanswered cycle
        clr_counts();
        request(1'b0, 32'h0000_0600, 4'hF, 32'h0);
        step(); drop_request();
        if (TO_EN) begin
            repeat (10) step();
            chk("to_err_pulses", err_cnt, 1);
            chk("to_stb_cycles", stb_cnt, TO + 1);
            chk("to_stall_cycles", stall_cnt, TO + 1);
            chk("to_cyc_dropped", {31'b0, wb_cyc_o}, 32'h0);
        end else begin
            repeat (110) step();
            chk("hang_stb_cycles", stb_cnt, 110);
            chk("hang_err", err_cnt, 0);
            chk("hang_stb_high", {31'b0, wb_stb_o}, 32'h1);
            flush_i = 1'b1;
            step(); flush_i = 1'b0;
            step();
            chk("hang_flush_stb", {31'b0, wb_stb_o}, 32'h0);
        end

        chk("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
